// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared data RAM between fetch and memory stages through a
// grant / RAM-cycle / response pipeline, with data priority and a fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_err,
    output logic              if_stall,
    output logic              dm_stall,
    output logic              halted
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t            r_state;
    logic [3:0]        r_streak;
    logic              r_b_vld, r_b_dm, r_b_we;
    logic [ADDR_W-1:0] r_b_addr;
    logic [DATA_W-1:0] r_b_wdata;
    logic              r_if_valid, r_if_err, r_dm_valid, r_dm_err;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;

    logic w_run, w_if_ok, w_streak_full, w_if_gnt, w_dm_gnt;

    // A flushed fetch is not eligible, so it never blocks the data side.
    always_comb begin
        w_run         = (r_state == RUN);
        w_if_ok       = if_req & ~if_flush;
        w_streak_full = (r_streak == STREAK_MAX);
        w_if_gnt      = w_run & w_if_ok & (~dm_req | w_streak_full);
        w_dm_gnt      = w_run & dm_req & ~w_if_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (!if_req || w_if_gnt) begin
            r_streak <= '0;
        end else if (w_dm_gnt && !w_streak_full) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_vld   <= 1'b0;
            r_b_dm    <= 1'b0;
            r_b_we    <= 1'b0;
            r_b_addr  <= '0;
            r_b_wdata <= '0;
        end else begin
            r_b_vld <= w_if_gnt | w_dm_gnt;
            if (w_if_gnt || w_dm_gnt) begin
                r_b_dm    <= w_dm_gnt;
                r_b_we    <= w_dm_gnt & dm_we;
                r_b_addr  <= w_dm_gnt ? dm_addr : if_addr;
                r_b_wdata <= w_dm_gnt ? dm_wdata : '0;
            end
        end
    end

    // Response capture; a fetch in the RAM cycle is dropped if flushed in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_if_valid <= 1'b0;
            r_if_rdata <= '0;
            r_if_err   <= 1'b0;
            r_dm_valid <= 1'b0;
            r_dm_rdata <= '0;
            r_dm_err   <= 1'b0;
        end else begin
            r_if_valid <= r_b_vld & ~r_b_dm & ~if_flush;
            r_dm_valid <= r_b_vld & r_b_dm;
            if (r_b_vld && !r_b_dm && !if_flush) begin
                r_if_rdata <= ram_rdata;
                r_if_err   <= ram_err;
            end
            if (r_b_vld && r_b_dm) begin
                r_dm_rdata <= r_b_we ? '0 : ram_rdata;
                r_dm_err   <= ram_err;
                if (ram_err) r_state <= HALT;
            end
        end
    end

    always_comb begin
        if_gnt    = w_if_gnt;
        dm_gnt    = w_dm_gnt;
        if_stall  = if_req & ~w_if_gnt;
        dm_stall  = dm_req & ~w_dm_gnt;
        ram_en    = r_b_vld;
        ram_we    = r_b_vld & r_b_we;
        ram_addr  = r_b_vld ? r_b_addr : '0;
        ram_wdata = (r_b_vld && r_b_we) ? r_b_wdata : '0;
        if_valid  = r_if_valid;
        if_rdata  = r_if_rdata;
        if_err    = r_if_err;
        dm_valid  = r_dm_valid;
        dm_rdata  = r_dm_rdata;
        dm_err    = r_dm_err;
        halted    = (r_state == HALT);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run scored against a transaction-level
// model of the arbiter, driving a 256-word RAM model that errors above 0xFF.
module tb_mem_port_arbiter;
    localparam int MAXS = 3;

    logic        clk, rst_n, load_mem;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata, ram_rdata;
    logic        ram_err;
    logic        if_gnt, if_valid, if_err, dm_gnt, dm_valid, dm_err;
    logic        ram_en, ram_we, if_stall, dm_stall, halted;
    logic [63:0] if_rdata, dm_rdata, ram_addr, ram_wdata;

    logic [63:0] tb_mem  [0:255];
    logic [63:0] mdl_mem [0:255];
    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_err(ram_err),
        .if_stall(if_stall), .dm_stall(dm_stall), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(int i);
        return (i == 16) ? 64'hA5 : {32'hC0DE0000, 32'(i * 7)};
    endfunction

    always_comb begin
        ram_rdata = '0;
        ram_err   = 1'b0;
        if (ram_en) begin
            if (ram_addr < 64'd256) ram_rdata = tb_mem[ram_addr[7:0]];
            else                    ram_err   = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
        end else if (ram_en && ram_we && !ram_err) begin
            tb_mem[ram_addr[7:0]] <= ram_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    endtask

    task automatic test_reset();
        logic [266:0] outs;
        rst_n = 0; load_mem = 1; idle_inputs();
        for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
        @(posedge clk); #1; load_mem = 0; #4;
        outs = {if_gnt, if_valid, if_rdata, if_err, dm_gnt, dm_valid, dm_rdata, dm_err,
                ram_en, ram_we, ram_addr, ram_wdata, if_stall, dm_stall, halted};
        n_vec++; if (outs !== '0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
        step(); rst_n = 1;
    endtask

    // Used both after power-on and after the mid-access reset.
    task automatic test_single_fetch();
        if_req = 1; if_addr = 64'h10; #4;
        n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL sf_gnt: got %b want 1", if_gnt); end
        n_vec++; if (if_stall !== 1'b0) begin n_err++; $display("FAIL sf_stall1: got %b want 0", if_stall); end
        step(); if_req = 0; #4;
        n_vec++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 64'h10}) begin
            n_err++; $display("FAIL sf_ram: got en=%b we=%b a=%h want 1 0 10", ram_en, ram_we, ram_addr); end
        n_vec++; if (if_valid !== 1'b0 || if_stall !== 1'b0) begin
            n_err++; $display("FAIL sf_c2: got valid=%b stall=%b want 0 0", if_valid, if_stall); end
        step(); #4;
        n_vec++; if ({if_valid, if_err, if_rdata} !== {2'b10, 64'hA5}) begin
            n_err++; $display("FAIL sf_resp: got v=%b e=%b d=%h want 1 0 a5", if_valid, if_err, if_rdata); end
        step(); #4;
        n_vec++; if (if_valid !== 1'b0 || if_rdata !== 64'hA5) begin
            n_err++; $display("FAIL sf_hold: got v=%b d=%h want 0 a5", if_valid, if_rdata); end
        step();
    endtask

    task automatic test_contention();
        logic [7:0] pat;
        pat = 8'b11101110;
        if_req = 1; if_addr = 64'h30; dm_req = 1; dm_we = 0; dm_addr = 64'h20;
        for (int i = 0; i < 8; i++) begin
            #4;
            n_vec++; if ({dm_gnt, if_gnt, if_stall, dm_stall} !== {pat[7-i], !pat[7-i], pat[7-i], !pat[7-i]}) begin
                n_err++; $display("FAIL contention[%0d]: got dg=%b ig=%b is=%b ds=%b want dg=%b",
                                  i, dm_gnt, if_gnt, if_stall, dm_stall, pat[7-i]); end
            step();
        end
        idle_inputs(); step(); step(); step();
    endtask

    task automatic test_raw();
        dm_req = 1; dm_we = 1; dm_addr = 64'h40; dm_wdata = 64'h1234; #4;
        n_vec++; if (dm_gnt !== 1'b1) begin n_err++; $display("FAIL raw_wgnt: got %b want 1", dm_gnt); end
        step(); dm_we = 0; dm_wdata = 0; #4;
        n_vec++; if ({dm_gnt, ram_we, ram_wdata} !== {2'b11, 64'h1234}) begin
            n_err++; $display("FAIL raw_rgnt: got g=%b we=%b wd=%h want 1 1 1234", dm_gnt, ram_we, ram_wdata); end
        step(); idle_inputs(); #4;
        n_vec++; if ({dm_valid, dm_rdata} !== {1'b1, 64'h0}) begin
            n_err++; $display("FAIL raw_wack: got v=%b d=%h want 1 0", dm_valid, dm_rdata); end
        step(); #4;
        n_vec++; if ({dm_valid, dm_err, dm_rdata} !== {2'b10, 64'h1234}) begin
            n_err++; $display("FAIL raw_read: got v=%b e=%b d=%h want 1 0 1234", dm_valid, dm_err, dm_rdata); end
        mdl_mem[8'h40] = 64'h1234;
        step(); step();
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 64'h11; #4;
        n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL fl_gnt: got %b want 1", if_gnt); end
        step(); if_addr = 64'h12; if_flush = 1; #4;
        n_vec++; if ({if_gnt, if_stall, ram_en} !== 3'b011) begin
            n_err++; $display("FAIL fl_c2: got g=%b s=%b en=%b want 0 1 1", if_gnt, if_stall, ram_en); end
        step(); idle_inputs(); #4;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fl_kill: got %b want 0", if_valid); end
        step(); #4;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fl_after: got %b want 0", if_valid); end
        step();
    endtask

    // Model: each requester holds a pending transaction until granted; a grant
    // reaches the RAM one cycle later and answers the cycle after that.
    task automatic test_random();
        int          streak = 0;
        bit          ip = 0, dp = 0, dw = 0, fl, eif, edm;
        logic [63:0] ia = 0, da = 0, dd = 0;
        bit          b_has = 0, b_dm = 0, b_we = 0;
        logic [63:0] b_a = 0, b_d = 0;
        bit          c_if = 0, c_dm = 0, c_er = 0, seen_if = 0, seen_dm = 0;
        logic [63:0] c_rd = 0, last_if = 0, last_dm = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1;
                ia = ($urandom_range(0, 7) == 0) ? 64'd300 + 64'($urandom_range(0, 99))
                                                 : 64'($urandom_range(0, 255));
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dw = 1'($urandom_range(0, 1));
                da = 64'($urandom_range(128, 255)); dd = {$urandom, $urandom};
            end
            fl = ($urandom_range(0, 5) == 0);
            if_req = ip; if_addr = ia; if_flush = fl;
            dm_req = dp; dm_we = dw; dm_addr = da; dm_wdata = dd;
            eif = ip && !fl && (!dp || streak == MAXS);
            edm = dp && !eif;
            #4;
            n_vec++; if ({if_gnt, dm_gnt, if_stall, dm_stall, halted} !== {eif, edm, ip && !eif, dp && !edm, 1'b0}) begin
                n_err++; $display("FAIL rnd_gnt[%0d]: got ig=%b dg=%b is=%b ds=%b h=%b want ig=%b dg=%b",
                                  i, if_gnt, dm_gnt, if_stall, dm_stall, halted, eif, edm); end
            n_vec++; if (ram_en !== b_has || (b_has && (ram_addr !== b_a || ram_we !== b_we ||
                                                         (b_we && ram_wdata !== b_d)))) begin
                n_err++; $display("FAIL rnd_ram[%0d]: got en=%b a=%h we=%b wd=%h want en=%b a=%h we=%b wd=%h",
                                  i, ram_en, ram_addr, ram_we, ram_wdata, b_has, b_a, b_we, b_d); end
            n_vec++; if (if_valid !== c_if || (c_if && (if_rdata !== c_rd || if_err !== c_er)) ||
                         (!c_if && seen_if && if_rdata !== last_if)) begin
                n_err++; $display("FAIL rnd_if[%0d]: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                  i, if_valid, if_rdata, if_err, c_if, c_if ? c_rd : last_if, c_er); end
            n_vec++; if (dm_valid !== c_dm || (c_dm && (dm_rdata !== c_rd || dm_err !== c_er)) ||
                         (!c_dm && seen_dm && dm_rdata !== last_dm)) begin
                n_err++; $display("FAIL rnd_dm[%0d]: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                                  i, dm_valid, dm_rdata, dm_err, c_dm, c_dm ? c_rd : last_dm, c_er); end
            if (c_if) begin seen_if = 1; last_if = c_rd; end
            if (c_dm) begin seen_dm = 1; last_dm = c_rd; end
            c_if = b_has && !b_dm && !fl;
            c_dm = b_has && b_dm;
            if (b_has) begin
                c_er = (b_a >= 64'd256);
                c_rd = (b_we || c_er) ? 64'h0 : mdl_mem[b_a[7:0]];
                if (b_we) mdl_mem[b_a[7:0]] = b_d;
            end
            b_has = eif || edm;
            if (eif) begin b_dm = 0; b_we = 0; b_a = ia; end
            if (edm) begin b_dm = 1; b_we = dw; b_a = da; b_d = dd; end
            if (!ip || eif) streak = 0;
            else if (edm && streak < MAXS) streak++;
            if (eif) ip = 0;
            if (edm) dp = 0;
            step();
        end
        idle_inputs(); step(); step(); step();
    endtask

    task automatic test_data_error();
        dm_req = 1; dm_we = 0; dm_addr = 64'h1000; #4;
        n_vec++; if (dm_gnt !== 1'b1) begin n_err++; $display("FAIL de_gnt: got %b want 1", dm_gnt); end
        step(); dm_req = 0; if_req = 1; if_addr = 64'h10; #4;
        n_vec++; if ({ram_en, if_gnt, halted} !== 3'b110) begin
            n_err++; $display("FAIL de_c2: got en=%b ig=%b h=%b want 1 1 0", ram_en, if_gnt, halted); end
        step(); if_req = 0; #4;
        n_vec++; if ({dm_valid, dm_err, halted, ram_en, ram_addr} !== {4'b1111, 64'h10}) begin
            n_err++; $display("FAIL de_resp: got v=%b e=%b h=%b en=%b a=%h want 1 1 1 1 10",
                              dm_valid, dm_err, halted, ram_en, ram_addr); end
        step(); #4;
        n_vec++; if ({if_valid, if_rdata, dm_valid} !== {1'b1, 64'hA5, 1'b0}) begin
            n_err++; $display("FAIL de_drain: got iv=%b d=%h dv=%b want 1 a5 0", if_valid, if_rdata, dm_valid); end
        for (int i = 0; i < 6; i++) begin
            step();
            if_req = 1'($urandom_range(0, 1)); dm_req = 1'($urandom_range(0, 1));
            dm_addr = 64'h90; if_addr = 64'h20; #4;
            n_vec++; if ({if_gnt, dm_gnt, if_stall, dm_stall, halted, ram_en} !== {2'b00, if_req, dm_req, 2'b10}) begin
                n_err++; $display("FAIL de_halt[%0d]: got ig=%b dg=%b is=%b ds=%b h=%b en=%b want 0 0 %b %b 1 0",
                                  i, if_gnt, dm_gnt, if_stall, dm_stall, halted, ram_en, if_req, dm_req); end
        end
        idle_inputs(); step();
    endtask

    task automatic test_reset_midop();
        logic [266:0] outs;
        rst_n = 0; step(); rst_n = 1;
        if_req = 1; if_addr = 64'h10; #4;
        n_vec++; if ({if_gnt, halted} !== 2'b10) begin
            n_err++; $display("FAIL rm_gnt: got g=%b h=%b want 1 0", if_gnt, halted); end
        step(); if_req = 0; #4;
        n_vec++; if (ram_en !== 1'b1) begin n_err++; $display("FAIL rm_en: got %b want 1", ram_en); end
        rst_n = 0; #1;
        outs = {if_gnt, if_valid, if_rdata, if_err, dm_gnt, dm_valid, dm_rdata, dm_err,
                ram_en, ram_we, ram_addr, ram_wdata, if_stall, dm_stall, halted};
        n_vec++; if (outs !== '0) begin n_err++; $display("FAIL rm_zero: got %h want 0", outs); end
        step(); rst_n = 1; #4;
        n_vec++; if ({if_valid, ram_en} !== 2'b00) begin
            n_err++; $display("FAIL rm_drop: got v=%b en=%b want 0 0", if_valid, ram_en); end
        step();
        test_single_fetch();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_raw();
        test_flush();
        test_random();
        test_data_error();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
